// File: rtl/uart_frame_tx.sv
// Purpose : packs an NBYTES game-state word into a framed byte stream
//           (SYNC, payload bytes LSB first, 8-bit additive checksum) and
//           feeds it to a UART transmitter one byte at a time.
// Latency : tx_start/tx_data for SYNC appear two cycles after send is sampled;
//           each following byte starts two cycles after the prior tx_done_tick.
// Backpressure: paced entirely by tx_done_tick; send is ignored while busy=1
//           (not queued), and frame_done marks the cycle a new send is accepted.
//
// Ports:
//   clk          - system clock, rising edge
//   reset        - asynchronous active-high reset
//   send         - frame request, honoured only while busy=0
//   payload      - 8*NBYTES state word, latched on the accepted send
//   tx_done_tick - transmitter pulse: current byte fully shifted out
//   tx_start     - one-cycle pulse launching tx_data
//   tx_data      - byte to transmit, held until its tx_done_tick
//   busy         - high while a frame is in progress
//   frame_done   - one-cycle pulse after the last byte completes
module uart_frame_tx #(
  parameter int          NBYTES = 4,
  parameter logic [7:0]  SYNC   = 8'hA5
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  send,
  input  logic [8*NBYTES-1:0]   payload,
  input  logic                  tx_done_tick,
  output logic                  tx_start,
  output logic [7:0]            tx_data,
  output logic                  busy,
  output logic                  frame_done
);

  localparam int                IDX_W    = $clog2(NBYTES + 2);
  localparam logic [IDX_W-1:0]  LAST_IDX = IDX_W'(NBYTES + 1);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_LOAD = 2'd1,
    S_WAIT = 2'd2
  } state_t;

  state_t                 state_q, state_d;
  logic [IDX_W-1:0]       idx_q, idx_d;
  logic [7:0]             csum_q, csum_d;
  logic [8*NBYTES-1:0]    payload_q, payload_d;
  logic                   tx_start_q, tx_start_d;
  logic [7:0]             tx_data_q, tx_data_d;
  logic                   busy_q, busy_d;
  logic                   frame_done_q, frame_done_d;
  logic [7:0]             pay_byte;

  // Payload byte for the current index; index i (1..NBYTES) maps to
  // latched byte i-1, so the least significant byte leaves first.
  always_comb begin
    pay_byte = 8'h00;
    for (int i = 0; i < NBYTES; i++) begin
      if (idx_q == IDX_W'(i + 1)) begin
        pay_byte = payload_q[8*i +: 8];
      end
    end
  end

  always_comb begin
    state_d      = state_q;
    idx_d        = idx_q;
    csum_d       = csum_q;
    payload_d    = payload_q;
    tx_start_d   = 1'b0;
    tx_data_d    = tx_data_q;
    busy_d       = busy_q;
    frame_done_d = 1'b0;

    case (state_q)
      S_IDLE: begin
        if (send) begin
          payload_d = payload;
          idx_d     = '0;
          csum_d    = 8'h00;
          busy_d    = 1'b1;
          state_d   = S_LOAD;
        end
      end

      S_LOAD: begin
        tx_start_d = 1'b1;
        state_d    = S_WAIT;
        if (idx_q == '0) begin
          tx_data_d = SYNC;
        end else if (idx_q == LAST_IDX) begin
          tx_data_d = csum_q;
        end else begin
          // Checksum is built from the latched copy as each payload byte
          // is launched, so it is complete by the time LAST_IDX is loaded.
          tx_data_d = pay_byte;
          csum_d    = csum_q + pay_byte;
        end
      end

      S_WAIT: begin
        if (tx_done_tick) begin
          if (idx_q == LAST_IDX) begin
            state_d      = S_IDLE;
            busy_d       = 1'b0;
            frame_done_d = 1'b1;
          end else begin
            idx_d   = idx_q + 1'b1;
            state_d = S_LOAD;
          end
        end
      end

      default: begin
        state_d = S_IDLE;
      end
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q      <= S_IDLE;
      idx_q        <= '0;
      csum_q       <= 8'h00;
      payload_q    <= '0;
      tx_start_q   <= 1'b0;
      tx_data_q    <= 8'h00;
      busy_q       <= 1'b0;
      frame_done_q <= 1'b0;
    end else begin
      state_q      <= state_d;
      idx_q        <= idx_d;
      csum_q       <= csum_d;
      payload_q    <= payload_d;
      tx_start_q   <= tx_start_d;
      tx_data_q    <= tx_data_d;
      busy_q       <= busy_d;
      frame_done_q <= frame_done_d;
    end
  end

  assign tx_start   = tx_start_q;
  assign tx_data    = tx_data_q;
  assign busy       = busy_q;
  assign frame_done = frame_done_q;

endmodule

// File: tb/tb_uart_frame_tx.sv
// Directed bench for uart_frame_tx (NBYTES=4, SYNC=A5) with a transmitter
// model that answers every tx_start with tx_done_tick 20 cycles later.
module tb_uart_frame_tx;

  logic        clk = 1'b0;
  logic        reset;
  logic        send;
  logic [31:0] payload;
  logic        tx_done_tick;
  logic        tx_start;
  logic [7:0]  tx_data;
  logic        busy;
  logic        frame_done;

  logic        resp_tick = 1'b0;
  logic        spur_tick = 1'b0;
  assign tx_done_tick = resp_tick | spur_tick;

  int checks   = 0;
  int failures = 0;
  int cyc      = 0;

  logic [7:0] bq[$];
  int         sq[$];
  int         fd_count = 0;
  int         fd_cyc   = 0;
  logic       fd_busy  = 1'b0;
  int         glitch   = 0;
  int         send_cyc = 0;

  uart_frame_tx #(.NBYTES(4), .SYNC(8'hA5)) dut (
    .clk          (clk),
    .reset        (reset),
    .send         (send),
    .payload      (payload),
    .tx_done_tick (tx_done_tick),
    .tx_start     (tx_start),
    .tx_data      (tx_data),
    .busy         (busy),
    .frame_done   (frame_done)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  // Transmitter model: tx_done_tick 20 cycles after each tx_start.
  initial begin : responder
    int cnt;
    cnt = 0;
    forever begin
      @(negedge clk);
      resp_tick = 1'b0;
      if (reset) begin
        cnt = 0;
      end else begin
        if (cnt > 0) begin
          cnt--;
          if (cnt == 0) resp_tick = 1'b1;
        end
        if (tx_start) cnt = 20;
      end
    end
  end

  // Byte/event recorder plus tx_start width and tx_data stability watch.
  initial begin : monitor
    logic [7:0] held;
    logic       prev_start;
    held = 8'h00;
    prev_start = 1'b0;
    forever begin
      @(negedge clk);
      if (reset) begin
        held = 8'h00;
      end else if (tx_start) begin
        bq.push_back(tx_data);
        sq.push_back(cyc);
        held = tx_data;
        if (prev_start) glitch++;
      end else if (busy && tx_data !== held) begin
        glitch++;
      end
      prev_start = tx_start;
      if (frame_done) begin
        fd_count++;
        fd_cyc  = cyc;
        fd_busy = busy;
      end
    end
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Caller is at a negedge; send is high for exactly one rising edge.
  task automatic pulse_send(input logic [31:0] p);
    payload  = p;
    send     = 1'b1;
    send_cyc = cyc;
    @(negedge clk);
    send = 1'b0;
  endtask

  task automatic wait_fd(input string tag, input int target);
    int n;
    n = 0;
    while (fd_count < target && n < 600) begin
      @(negedge clk);
      n++;
    end
    #1;
    chk(tag, 32'(fd_count >= target), 32'd1);
  endtask

  task automatic wait_bytes(input string tag, input int target);
    int n;
    n = 0;
    while (bq.size() < target && n < 600) begin
      @(negedge clk);
      #1;
      n++;
    end
    chk(tag, 32'(bq.size() >= target), 32'd1);
  endtask

  // exp lists the six frame bytes first-to-last, most significant first.
  task automatic chk_frame(input string tag, input logic [47:0] exp, input int base);
    logic [7:0] obs;
    for (int i = 0; i < 6; i++) begin
      if (base + i < bq.size()) obs = bq[base + i];
      else obs = 8'hxx;
      chk($sformatf("%s_byte%0d", tag, i), {24'h0, obs}, {24'h0, exp[47 - 8*i -: 8]});
    end
  endtask

  initial begin : stim
    int fd0;
    int bdone_cyc;
    int n;

    reset   = 1'b1;
    send    = 1'b0;
    payload = 32'h0;
    repeat (3) @(negedge clk);
    chk("rst_tx_start",   {31'h0, tx_start},   32'h0);
    chk("rst_tx_data",    {24'h0, tx_data},    32'h0);
    chk("rst_busy",       {31'h0, busy},       32'h0);
    chk("rst_frame_done", {31'h0, frame_done}, 32'h0);
    reset = 1'b0;
    repeat (2) @(negedge clk);

    // Single frame with timing checks.
    bq.delete(); sq.delete(); fd0 = fd_count;
    pulse_send(32'h04030201);
    chk("t1_busy_after_send", {31'h0, busy}, 32'h1);
    wait_fd("t1_frame_done_seen", fd0 + 1);
    chk_frame("t1", 48'hA5_01_02_03_04_0A, 0);
    chk("t1_nstart", bq.size(), 6);
    chk("t1_nframe_done", fd_count - fd0, 1);
    chk("t1_first_start_latency", sq[0] - send_cyc, 2);
    chk("t1_inter_byte_gap", sq[1] - sq[0], 22);
    chk("t1_done_after_last", fd_cyc - sq[5], 21);
    chk("t1_busy_at_done", {31'h0, fd_busy}, 32'h0);
    @(negedge clk);
    chk("t1_busy_after", {31'h0, busy}, 32'h0);

    // Checksum wraps modulo 256.
    bq.delete(); sq.delete(); fd0 = fd_count;
    pulse_send(32'hFFFFFFFF);
    wait_fd("t2_frame_done_seen", fd0 + 1);
    chk_frame("t2", 48'hA5_FF_FF_FF_FF_FC, 0);
    chk("t2_nstart", bq.size(), 6);

    // send while busy is ignored; payload changes do not leak in.
    @(negedge clk);
    bq.delete(); sq.delete(); fd0 = fd_count;
    pulse_send(32'h11223344);
    wait_bytes("t3_reach_byte2", 3);
    @(negedge clk);
    pulse_send(32'hAAAAAAAA);
    wait_fd("t3_frame_done_seen", fd0 + 1);
    repeat (150) @(negedge clk);
    #1;
    chk_frame("t3", 48'hA5_44_33_22_11_AA, 0);
    chk("t3_nstart", bq.size(), 6);
    chk("t3_nframe_done", fd_count - fd0, 1);

    // Back-to-back frame requested in the frame_done cycle.
    @(negedge clk);
    bq.delete(); sq.delete(); fd0 = fd_count;
    pulse_send(32'h04030201);
    n = 0;
    while (frame_done !== 1'b1 && n < 600) begin
      @(negedge clk);
      n++;
    end
    bdone_cyc = cyc;
    chk("t4_frame_done_seen", {31'h0, frame_done}, 32'h1);
    pulse_send(32'h00000005);
    wait_fd("t4_second_done_seen", fd0 + 2);
    chk_frame("t4_first", 48'hA5_01_02_03_04_0A, 0);
    chk_frame("t4_second", 48'hA5_05_00_00_00_05, 6);
    chk("t4_nstart", bq.size(), 12);
    chk("t4_b2b_latency", sq[6] - bdone_cyc, 2);

    // Reset while waiting on byte 3.
    @(negedge clk);
    bq.delete(); sq.delete();
    pulse_send(32'h11111111);
    wait_bytes("t5_reach_byte3", 4);
    repeat (3) @(negedge clk);
    reset = 1'b1;
    #1;
    chk("t5_rst_tx_start",   {31'h0, tx_start},   32'h0);
    chk("t5_rst_tx_data",    {24'h0, tx_data},    32'h0);
    chk("t5_rst_busy",       {31'h0, busy},       32'h0);
    chk("t5_rst_frame_done", {31'h0, frame_done}, 32'h0);
    @(negedge clk);
    reset = 1'b0;
    @(negedge clk);
    bq.delete(); sq.delete(); fd0 = fd_count;
    pulse_send(32'h01010101);
    wait_fd("t5_frame_done_seen", fd0 + 1);
    chk_frame("t5", 48'hA5_01_01_01_01_04, 0);
    chk("t5_nstart", bq.size(), 6);

    // Spurious tx_done_tick in IDLE (x3) and during LOAD.
    @(negedge clk);
    bq.delete(); sq.delete(); fd0 = fd_count;
    repeat (3) begin
      spur_tick = 1'b1;
      @(negedge clk);
      spur_tick = 1'b0;
      @(negedge clk);
    end
    #1;
    chk("t6_idle_no_start", bq.size(), 0);
    chk("t6_idle_no_done", fd_count - fd0, 0);
    chk("t6_idle_busy", {31'h0, busy}, 32'h0);
    @(negedge clk);
    pulse_send(32'h04030201);
    spur_tick = 1'b1;
    @(negedge clk);
    spur_tick = 1'b0;
    wait_fd("t6_frame_done_seen", fd0 + 1);
    chk_frame("t6", 48'hA5_01_02_03_04_0A, 0);
    chk("t6_nstart", bq.size(), 6);
    chk("t6_first_start_latency", sq[0] - send_cyc, 2);

    chk("tx_start_width_and_data_stability", glitch, 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/uart_frame_tx.md
# uart_frame_tx

Frame serializer that sits directly upstream of the UART transmitter. It packs a multi-byte game-state word into a framed byte stream: sync byte, payload bytes, then checksum. It drives the transmitter byte by byte using the `tx_start` / `tx_done_tick` handshake. It lets game logic send a complete state snapshot with a single `send` pulse, with no byte-level sequencing.

## Interface
- `NBYTES`, 4: payload bytes per frame; legal range is ≥1.
- `SYNC`, 8'hA5: first byte of every frame.
- `clk` input 1: system clock; all logic is on the rising edge.
- `reset` input 1: asynchronous, active-high reset.
- `send` input 1: frame request, sampled each cycle; honoured only while `busy`=0.
- `payload` input 8*NBYTES: state word, latched on the accepted `send`.
- `tx_done_tick` input 1: one-cycle pulse from the transmitter when the current byte has fully shifted out.
- `tx_start` output 1: one-cycle pulse that starts transmission of `tx_data`.
- `tx_data` output 8: byte to transmit.
- `busy` output 1: high while a frame is in progress.
- `frame_done` output 1: one-cycle pulse after the last byte completes.

## Operation
- **Reset values:**
  - `tx_start`=0, `tx_data`=8'h00, `busy`=0, `frame_done`=0.
  - FSM is in IDLE.
  - Byte index and checksum are 0.
  - Latched payload is 0.
- **FSM states:** IDLE, LOAD, WAIT.
  - **IDLE:** `send`=1 latches `payload` into an internal register, clears the index and checksum, sets `busy`=1, and goes to LOAD.
  - **LOAD:** selects the byte for the current index, registers it onto `tx_data`, pulses `tx_start`, and goes to WAIT.
  - **WAIT:** holds `tx_data`.
    - On `tx_done_tick`, if the index is less than NBYTES+1: increment the index and go to LOAD.
    - If the index equals NBYTES+1: go to IDLE, pulse `frame_done`, and clear `busy`.
- **Byte order** (index 0..NBYTES+1):
  - Index 0 is `SYNC`.
  - Index i, for 1..NBYTES, is `payload[8*(i-1)+7 : 8*(i-1)]`, so the LSB byte goes first.
  - Index NBYTES+1 is the checksum.
- **Checksum:**
  - 8-bit sum modulo 256 of the payload bytes only; `SYNC` is excluded.
  - Carries are discarded.
  - Accumulated from the latched copy, so it is independent of later changes on `payload`.
- **Index counter:** width is `$clog2(NBYTES+2)`, with no wrap inside a frame.
- **`send` while `busy`=1:** ignored; it is neither queued nor allowed to corrupt the latched payload.
- **`tx_done_tick` in IDLE or LOAD:** ignored, with no state change.
- **`payload` changes mid-frame:** have no effect on the frame in flight.
- **`reset` mid-frame:** all outputs return to their reset values asynchronously and the frame is abandoned. The transmitter is reset by the same signal, so no partial byte is resumed.

## Timing
- **Latency:** `send` is sampled high in IDLE at edge t. Then `busy`=1 from t, and `tx_start`=1 with `tx_data`=`SYNC` in the cycle after t+1 (LOAD is registered).
- **Inter-byte gap:** `tx_done_tick` is high in cycle k. The next `tx_start` pulse is high in cycle k+2 (WAIT→LOAD at k+1, pulse registered out of LOAD).
- **`tx_data` stability:** stable from its `tx_start` cycle through the matching `tx_done_tick` cycle inclusive.
- **`tx_start` width:** exactly one cycle per byte, with exactly NBYTES+2 pulses per frame.
- **Frame end:** `frame_done` is high in the cycle after the final `tx_done_tick`. `busy` reads 0 in that same cycle, and a `send` in that cycle is accepted, which gives back-to-back frames.
- **Throughput:** per frame, (NBYTES+2) × (UART byte time + 2) cycles.

## Test plan
- **Single frame:** NBYTES=4, `payload`=32'h04030201, one `send` pulse; the bench model returns `tx_done_tick` 20 cycles after each `tx_start`.
  - Required: `tx_data` sequence A5,01,02,03,04,0A.
  - Required: 6 `tx_start` pulses, then one `frame_done`, then `busy`=0.
- **Checksum wrap:** `payload`=32'hFFFFFFFF.
  - Required: bytes A5,FF,FF,FF,FF,FC.
- **Busy rejection and payload isolation:** `send` with 32'h11223344; then, during byte 2, `send` again with 32'hAAAAAAAA and change `payload`.
  - Required: a single frame A5,44,33,22,11,AA and no second frame.
- **Back-to-back:** assert `send` with 32'h00000005 in the `frame_done` cycle of a previous frame.
  - Required: a second frame A5,05,00,00,00,05 whose first `tx_start` is 2 cycles after `frame_done`.
- **Reset mid-frame:** assert `reset` while in WAIT on byte 3.
  - Required: `tx_start`/`busy`/`frame_done`=0 and `tx_data`=00 immediately.
  - Required: a subsequent `send` with 32'h01010101 yields A5,01,01,01,01,04.
- **Spurious done:** pulse `tx_done_tick` 3 times in IDLE, and once during LOAD.
  - Required: no `tx_start`, no `frame_done`, no byte skipped; the frame content is unchanged.
